// File: rtl/pipelined_adder_nbit_if.sv
// Valid/ready operand and result bus for the pipelined adder/subtractor.
// Producer/consumer side uses master, the adder uses slave.
interface pipelined_adder_nbit_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, a, b, cin, mode, out_ready,
        input  in_ready, out_valid, s, cout, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, cin, mode, out_ready,
        output in_ready, out_valid, s, cout, ovf, zero
    );
endinterface

// File: rtl/pipelined_adder_nbit.sv
// Pipelined N-bit adder/subtractor: carry chain cut into STAGES slices,
// one register boundary per slice, whole-pipe stall on backpressure.
module pipelined_adder_nbit #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input logic                   clk,
    input logic                   rst_n,
    pipelined_adder_nbit_if.slave bus
);
    localparam int SW = WIDTH / STAGES;

    logic [STAGES-1:0]            valid_q, valid_d;
    logic [STAGES-1:0][WIDTH-1:0] res_q, res_d;
    logic [STAGES-1:0][WIDTH-1:0] opa_q, opa_d;
    logic [STAGES-1:0][WIDTH-1:0] opb_q, opb_d;
    logic [STAGES-1:0]            carry_q, carry_d;
    logic [STAGES-1:0]            amsb_q, amsb_d;
    logic [STAGES-1:0]            bmsb_q, bmsb_d;

    logic                         advance;
    logic [WIDTH-1:0]             b_eff;
    logic                         c_in;
    logic [STAGES-1:0][SW:0]      slice_sum;

    always_comb begin
        advance   = !valid_q[STAGES-1] || bus.out_ready;
        b_eff     = bus.mode ? ~bus.b : bus.b;
        c_in      = bus.mode | bus.cin;
        slice_sum = '0;
        valid_d   = '0;
        res_d     = '0;
        opa_d     = '0;
        opb_d     = '0;
        carry_d   = '0;
        amsb_d    = '0;
        bmsb_d    = '0;

        slice_sum[0] = {1'b0, bus.a[SW-1:0]}
                     + {1'b0, b_eff[SW-1:0]}
                     + {{SW{1'b0}}, c_in};
        valid_d[0] = bus.in_valid;
        // Bubbles carry all-zero data so idle outputs read zero.
        if (bus.in_valid) begin
            res_d[0][SW-1:0] = slice_sum[0][SW-1:0];
            opa_d[0]         = bus.a;
            opb_d[0]         = b_eff;
            carry_d[0]       = slice_sum[0][SW];
            amsb_d[0]        = bus.a[WIDTH-1];
            bmsb_d[0]        = b_eff[WIDTH-1];
        end

        for (int k = 1; k < STAGES; k++) begin
            slice_sum[k] = {1'b0, opa_q[k-1][k*SW +: SW]}
                         + {1'b0, opb_q[k-1][k*SW +: SW]}
                         + {{SW{1'b0}}, carry_q[k-1]};
            valid_d[k]             = valid_q[k-1];
            res_d[k]               = res_q[k-1];
            res_d[k][k*SW +: SW]   = slice_sum[k][SW-1:0];
            opa_d[k]               = opa_q[k-1];
            opb_d[k]               = opb_q[k-1];
            carry_d[k]             = slice_sum[k][SW];
            amsb_d[k]              = amsb_q[k-1];
            bmsb_d[k]              = bmsb_q[k-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            res_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            carry_q <= '0;
            amsb_q  <= '0;
            bmsb_q  <= '0;
        end else if (advance) begin
            valid_q <= valid_d;
            res_q   <= res_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            carry_q <= carry_d;
            amsb_q  <= amsb_d;
            bmsb_q  <= bmsb_d;
        end
    end

    assign bus.in_ready  = advance;
    assign bus.out_valid = valid_q[STAGES-1];
    assign bus.s         = res_q[STAGES-1];
    assign bus.cout      = carry_q[STAGES-1];
    assign bus.ovf       = valid_q[STAGES-1]
                         & (amsb_q[STAGES-1] == bmsb_q[STAGES-1])
                         & (res_q[STAGES-1][WIDTH-1] != amsb_q[STAGES-1]);
    assign bus.zero      = valid_q[STAGES-1] & ~|res_q[STAGES-1];

    // Operand bits of already-summed slices are never read again.
    logic unused_ok;
    assign unused_ok = ^{opa_q, opb_q};
endmodule

// File: tb/tb_pipelined_adder_nbit.sv
// Scoreboard bench: 16/4 pipeline with randomized traffic and backpressure,
// plus a 4-bit single-stage instance.
module tb_pipelined_adder_nbit;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    pipelined_adder_nbit_if #(.WIDTH(16)) bus ();
    pipelined_adder_nbit_if #(.WIDTH(4))  bus4 ();

    pipelined_adder_nbit #(.WIDTH(16), .STAGES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    pipelined_adder_nbit #(.WIDTH(4), .STAGES(1)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4.slave)
    );

    typedef struct {
        logic [15:0] s;
        logic        cout;
        logic        ovf;
        logic        zero;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    // Reference: plain integer arithmetic on unsigned and signed views.
    function automatic exp_t model(input int w, input logic [15:0] a,
                                   input logic [15:0] b,
                                   input logic cin, input logic mode);
        exp_t   e;
        longint full, half, ua, ub, sa, sb, ru, rs;
        full = longint'(1) << w;
        half = longint'(1) << (w - 1);
        ua   = longint'(a);
        ub   = longint'(b);
        sa   = (ua >= half) ? ua - full : ua;
        sb   = (ub >= half) ? ub - full : ub;
        if (mode) begin
            ru     = ua - ub;
            rs     = sa - sb;
            e.cout = (ua >= ub);
        end else begin
            ru     = ua + ub + longint'(cin);
            rs     = sa + sb + longint'(cin);
            e.cout = (ru >= full);
        end
        if (ru < 0) ru = ru + full;
        if (ru >= full) ru = ru - full;
        e.s    = 16'(ru);
        e.ovf  = (rs >= half) || (rs < -half);
        e.zero = (ru == 0);
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: actual s=%h required none",
                             bus.s);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("res_s", 32'(bus.s), 32'(mon_e.s));
                    chk("res_cout", 32'(bus.cout), 32'(mon_e.cout));
                    chk("res_ovf", 32'(bus.ovf), 32'(mon_e.ovf));
                    chk("res_zero", 32'(bus.zero), 32'(mon_e.zero));
                end
            end
            if (bus.in_valid && bus.in_ready)
                exp_q.push_back(model(16, bus.a, bus.b, bus.cin, bus.mode));
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic mode);
        bus.in_valid = 1'b1;
        bus.a        = a;
        bus.b        = b;
        bus.cin      = cin;
        bus.mode     = mode;
    endtask

    task automatic drive_rand;
        drive(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    endtask

    task automatic single(input string name, input logic [15:0] a,
                          input logic [15:0] b, input logic cin,
                          input logic mode, input logic [15:0] rs,
                          input logic rc, input logic ro, input logic rz);
        drive(a, b, cin, mode);
        tick;
        bus.in_valid = 1'b0;
        for (int j = 0; j < 4; j++) begin
            chk({name, "_valid"}, 32'(bus.out_valid), 32'(j == 3));
            if (j < 3) tick;
        end
        chk({name, "_s"}, 32'(bus.s), 32'(rs));
        chk({name, "_cout"}, 32'(bus.cout), 32'(rc));
        chk({name, "_ovf"}, 32'(bus.ovf), 32'(ro));
        chk({name, "_zero"}, 32'(bus.zero), 32'(rz));
        tick;
    endtask

    task automatic drain(input string name);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int j = 0; j < 8; j++) tick;
        chk(name, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    logic [15:0] snap_s;
    logic [2:0]  snap_f;
    logic [15:0] ra, rb;
    logic        rc, rm;
    exp_t        e4;

    initial begin
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.mode      = 1'b0;
        bus.out_ready = 1'b1;
        bus4.in_valid  = 1'b0;
        bus4.a         = '0;
        bus4.b         = '0;
        bus4.cin       = 1'b0;
        bus4.mode      = 1'b0;
        bus4.out_ready = 1'b1;

        #1 rst_n = 1'b0;
        #1;
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_s", 32'(bus.s), 32'd0);
        chk("rst_cout", 32'(bus.cout), 32'd0);
        chk("rst_ovf", 32'(bus.ovf), 32'd0);
        chk("rst_zero", 32'(bus.zero), 32'd0);
        chk("rst_valid4", 32'(bus4.out_valid), 32'd0);
        tick;
        rst_n = 1'b1;
        tick;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

        single("add_8000", 16'h8000, 16'h8000, 1'b0, 1'b0,
               16'h0000, 1'b1, 1'b1, 1'b1);
        single("ripple", 16'hFFFF, 16'h0000, 1'b1, 1'b0,
               16'h0000, 1'b1, 1'b0, 1'b1);
        single("sub_5_7", 16'h0005, 16'h0007, 1'b1, 1'b1,
               16'hFFFE, 1'b0, 1'b0, 1'b0);
        single("sub_8000_1", 16'h8000, 16'h0001, 1'b0, 1'b1,
               16'h7FFF, 1'b1, 1'b1, 1'b0);

        drive_rand;
        for (int j = 0; j < 13; j++) begin
            tick;
            chk("stream_valid", 32'(bus.out_valid), 32'(j >= 3 && j <= 10));
            if (j < 7) drive_rand;
            else bus.in_valid = 1'b0;
        end
        chk("stream_empty", 32'(exp_q.size()), 32'd0);

        for (int j = 0; j < 4; j++) begin
            drive_rand;
            tick;
        end
        chk("bp_full", 32'(bus.out_valid), 32'd1);
        drive_rand;
        bus.out_ready = 1'b0;
        #1;
        snap_s = bus.s;
        snap_f = {bus.cout, bus.ovf, bus.zero};
        for (int j = 0; j < 3; j++) begin
            tick;
            chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
            chk("bp_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_s", 32'(bus.s), 32'(snap_s));
            chk("bp_flags", 32'({bus.cout, bus.ovf, bus.zero}), 32'(snap_f));
        end
        bus.out_ready = 1'b1;
        tick;
        drain("bp_drain");

        for (int j = 0; j < 60; j++) begin
            if ($urandom_range(0, 3) != 0) drive_rand;
            else bus.in_valid = 1'b0;
            bus.out_ready = ($urandom_range(0, 2) != 0);
            tick;
        end
        drain("rand_drain");

        for (int j = 0; j < 6; j++) begin
            drive_rand;
            tick;
        end
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_s", 32'(bus.s), 32'd0);
        tick;
        rst_n = 1'b1;
        tick;
        chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
        for (int j = 0; j < 4; j++) begin
            drive_rand;
            tick;
        end
        drain("post_rst_drain");

        bus4.in_valid = 1'b1;
        bus4.a        = 4'b1011;
        bus4.b        = 4'b1011;
        bus4.cin      = 1'b0;
        bus4.mode     = 1'b0;
        tick;
        chk("w4_valid", 32'(bus4.out_valid), 32'd1);
        chk("w4_s", 32'(bus4.s), 32'b0110);
        chk("w4_cout", 32'(bus4.cout), 32'd1);
        for (int j = 0; j < 10; j++) begin
            ra = 16'($urandom_range(0, 15));
            rb = 16'($urandom_range(0, 15));
            rc = 1'($urandom);
            rm = 1'($urandom);
            bus4.a    = ra[3:0];
            bus4.b    = rb[3:0];
            bus4.cin  = rc;
            bus4.mode = rm;
            tick;
            e4 = model(4, ra, rb, rc, rm);
            chk("w4r_valid", 32'(bus4.out_valid), 32'd1);
            chk("w4r_s", 32'(bus4.s), 32'(e4.s[3:0]));
            chk("w4r_flags", 32'({bus4.cout, bus4.ovf, bus4.zero}),
                32'({e4.cout, e4.ovf, e4.zero}));
        end
        bus4.in_valid = 1'b0;
        tick;
        chk("w4_idle", 32'(bus4.out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipelined_adder_nbit.md
# pipelined_adder_nbit

Parametrised, pipelined N-bit adder/subtractor. It is the streaming successor to the team's 4-bit ripple parallel adder. The carry chain is split into STAGES equal slices with one register boundary per slice, so wide operands close timing at full throughput. It sits between operand producers and consumers, using valid/ready handshakes on both sides, and reports carry, signed overflow and zero flags with each result.

## Interface
- WIDTH, 16: operand/result width in bits; must be a multiple of STAGES, ≥ 1.
- STAGES, 4: number of pipeline slices; each slice adds WIDTH/STAGES bits; 1 ≤ STAGES ≤ WIDTH.
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand set present.
- in_ready  output  1  block can accept this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in; used only when mode=0.
- mode  input  1  0 = add (a+b+cin), 1 = subtract (a+~b+1; cin ignored).
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts result.
- s  output  WIDTH  sum/difference, modulo 2^WIDTH.
- cout  output  1  carry out of MSB; in subtract, 1 = no borrow (a ≥ b unsigned).
- ovf  output  1  two's-complement signed overflow.
- zero  output  1  s == 0.

## Operation
- Slice k covers bits [k·W/S + W/S − 1 : k·W/S], where W = WIDTH and S = STAGES.
- Stage register k holds:
  - valid bit;
  - result bits of slices 0..k;
  - operand bits (a, b already inverted if mode=1) of slices k+1..S−1;
  - carry into slice k+1;
  - MSB sign bits of a and effective b.
- Stage 0 loads on accept: slice 0 is computed from the inputs, with carry-in = cin (mode=0) or 1 (mode=1).
- Stage k (k ≥ 1) loads from stage k−1. It computes slice k with the registered carry; upper operands shift along unchanged.
- Output ports are driven directly from stage S−1 registers. Flags come from its full result:
  - cout = carry out of slice S−1;
  - ovf = (a_msb == beff_msb) && (s[W−1] != a_msb);
  - zero = ~|s.
- advance = !out_valid || out_ready. All stages load together when advance=1 and hold when advance=0; there is no partial stall.
- in_ready = advance. A transfer occurs when in_valid && in_ready. If in_valid=0 while advance=1, a bubble (valid=0) enters stage 0.
- Results leave in acceptance order. Nothing is dropped, duplicated or reordered.
- STAGES=1 degenerates to a registered full-width ripple adder.

## Timing
- Reset (rst_n=0, any time, asynchronous): all valid bits 0, all data registers 0. Outputs read out_valid=0, s=0, cout=0, ovf=0, zero=0. in_ready=1 from the first cycle after reset release.
- Reset mid-operation discards all in-flight operations. No result from before reset ever appears.
- Latency: an operand accepted at edge E produces out_valid=1 with its result after edge E+STAGES−1, i.e. STAGES cycles counting the accept cycle.
- Throughput: one operation per cycle while out_ready=1.
- Backpressure: while out_valid=1 && out_ready=0, s/cout/ovf/zero hold stable, in_ready=0, and all stages freeze.
- out_ready=1 with out_valid=0 is legal. The pipeline advances and in_ready=1.
- Simultaneous accept at input and output in the same cycle is legal. Both transfers complete.
- Inputs are sampled only on accepting edges. a/b/mode/cin may change freely otherwise.

## Test plan
- Default params; add 0x8000+0x8000, cin=0. Required: after 4 cycles s=0x0000, cout=1, ovf=1, zero=1.
- Full carry ripple across all slices: 0xFFFF+0x0000, cin=1. Required: s=0x0000, cout=1, ovf=0, zero=1.
- Subtract 0x0005−0x0007. Required: s=0xFFFE, cout=0, ovf=0, zero=0. Subtract 0x8000−0x0001. Required: s=0x7FFF, cout=1, ovf=1.
- Stream 8 back-to-back random ops with out_ready=1. Required:
  - out_valid high for 8 consecutive cycles starting 4 cycles after the first accept;
  - results match the reference model in order.
- Hold out_ready=0 for 3 cycles with the pipeline full. Required:
  - outputs stable and in_ready=0 throughout;
  - after release, all results delivered in order with no loss.
- Assert rst_n=0 mid-stream for 1 cycle. Required:
  - out_valid=0 immediately;
  - no pre-reset results emerge;
  - WIDTH=4, STAGES=1 rerun: 1011+1011 gives s=0110, cout=1 one cycle after accept.
